// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer (boot, +4, branch, jump, interrupt, eret).
// Define PC_SEQ_DELAY_SLOT_EN to give branches and jumps one delay slot.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BOOT0_VEC = 0,
  parameter logic [WIDTH-1:0] BOOT1_VEC = 15,
  parameter logic [WIDTH-1:0] BOOT2_VEC = 25,
  parameter logic [WIDTH-1:0] IRQ_VEC   = 'h80
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       boot_sel,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             interrupt,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             irq_ack,
  output logic             in_handler
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HANDLER} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_pc, r_epc;
  logic             r_pc_valid, r_irq_ack, r_irq_pending, r_int_prev;
  logic [WIDTH-1:0] w_seq, w_tgt, w_npc, w_boot_vec;
  logic             w_redir, w_edge, w_slot, w_take;
  assign w_seq      = r_pc + WIDTH'(4);
  assign w_redir    = jump | branch_taken;
  assign w_tgt      = jump ? {jump_target[WIDTH-1:2], 2'b00} : {branch_target[WIDTH-1:2], 2'b00};
  assign w_npc      = w_redir ? w_tgt : w_seq;
  assign w_edge     = interrupt & ~r_int_prev;
  assign w_boot_vec = boot_sel == 2'b01 ? BOOT1_VEC : boot_sel == 2'b11 ? BOOT2_VEC : BOOT0_VEC;
`ifdef PC_SEQ_DELAY_SLOT_EN
  logic             r_rp;
  logic [WIDTH-1:0] r_ra;
  assign w_slot = r_rp;
`else
  assign w_slot = 1'b0;
`endif
  assign w_take = r_state == S_RUN && !stall && r_irq_pending && !w_slot;
  // A fresh edge coinciding with the take is dropped: the take wins the pending bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_BOOT;
      r_pc          <= '0;
      r_epc         <= '0;
      r_pc_valid    <= 1'b0;
      r_irq_ack     <= 1'b0;
      r_irq_pending <= 1'b0;
      r_int_prev    <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
      r_rp          <= 1'b0;
      r_ra          <= '0;
`endif
    end else begin
      r_int_prev <= interrupt;
      r_irq_ack  <= w_take;
      if (w_take) r_irq_pending <= 1'b0;
      else if (w_edge && r_state != S_BOOT) r_irq_pending <= 1'b1;
      if (r_state == S_BOOT) begin
        r_pc       <= w_boot_vec;
        r_pc_valid <= 1'b1;
        r_state    <= S_RUN;
      end else if (!stall) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
        if (r_rp) begin
          r_pc <= r_ra;
          r_rp <= 1'b0;
        end else
`endif
        if (w_take) begin
          r_epc   <= w_npc;
          r_pc    <= IRQ_VEC;
          r_state <= S_HANDLER;
        end else if (r_state == S_HANDLER && eret) begin
          r_pc    <= r_epc;
          r_state <= S_RUN;
        end else begin
`ifdef PC_SEQ_DELAY_SLOT_EN
          if (w_redir) begin
            r_rp <= 1'b1;
            r_ra <= w_tgt;
          end
          r_pc <= w_seq;
`else
          r_pc <= w_npc;
`endif
        end
      end
    end
  end
  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign epc        = r_epc;
  assign irq_ack    = r_irq_ack;
  assign in_handler = r_state == S_HANDLER;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (default build, no delay slot).
module tb_pc_sequencer;
  logic        clock = 1'b0, reset = 1'b0;
  logic [1:0]  boot_sel = 2'b00;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, interrupt = 1'b0, eret = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, epc;
  logic        pc_valid, irq_ack, in_handler;
  int          n_tests = 0, n_fail = 0;
  typedef struct {logic [31:0] pc, epc; logic ack, h, v;} exp_t;
  exp_t        q[$];
  always #5 clock = ~clock;
  pc_sequencer dut (
    .clock(clock), .reset(reset), .boot_sel(boot_sel), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .interrupt(interrupt), .eret(eret),
    .pc(pc), .pc_valid(pc_valid), .epc(epc), .irq_ack(irq_ack), .in_handler(in_handler)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic [31:0] p, input logic [31:0] e, input logic a, input logic h);
    exp_t x;
    q.push_back('{pc: p, epc: e, ack: a, h: h, v: 1'b1});
    @(posedge clock);
    #1;
    x = q.pop_front();
    chk("pc", pc, x.pc);
    chk("epc", epc, x.epc);
    chk("irq_ack", {31'b0, irq_ack}, {31'b0, x.ack});
    chk("in_handler", {31'b0, in_handler}, {31'b0, x.h});
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, x.v});
  endtask
  task automatic go(input logic [31:0] t);
    jump = 1'b1;
    jump_target = t;
  endtask
  initial begin
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_ack", {31'b0, irq_ack}, 32'h0);
    chk("rst_h", {31'b0, in_handler}, 32'h0);
    boot_sel = 2'b01;
    @(posedge clock); #1;
    chk("rst_hold", pc, 32'h0);
    reset = 1'b1; stall = 1'b1;
    tick(32'd15, 0, 0, 0);
    stall = 1'b0;
    reset = 1'b0; #1; boot_sel = 2'b11; reset = 1'b1;
    tick(32'd25, 0, 0, 0);
    reset = 1'b0; #1; boot_sel = 2'b10; reset = 1'b1;
    tick(32'd0, 0, 0, 0);
    eret = 1'b1;
    tick(32'h4, 0, 0, 0);
    eret = 1'b0;
    go(32'hFFFF_FFF8);
    tick(32'hFFFF_FFF8, 0, 0, 0);
    jump = 1'b0;
    tick(32'hFFFF_FFFC, 0, 0, 0);
    tick(32'h0, 0, 0, 0);
    tick(32'h4, 0, 0, 0);
    go(32'h100);
    tick(32'h100, 0, 0, 0);
    branch_taken = 1'b1; branch_target = 32'h200; jump_target = 32'h400;
    tick(32'h400, 0, 0, 0);
    jump = 1'b0; branch_target = 32'h203;
    tick(32'h200, 0, 0, 0);
    branch_taken = 1'b0;
    go(32'h40);
    tick(32'h40, 0, 0, 0);
    jump = 1'b0; stall = 1'b1; interrupt = 1'b1;
    tick(32'h40, 0, 0, 0);
    tick(32'h40, 0, 0, 0);
    stall = 1'b0;
    tick(32'h80, 32'h44, 1, 1);
    tick(32'h84, 32'h44, 0, 1);
    interrupt = 1'b0;
    tick(32'h88, 32'h44, 0, 1);
    interrupt = 1'b1;
    tick(32'h8C, 32'h44, 0, 1);
    interrupt = 1'b0; stall = 1'b1; eret = 1'b1;
    tick(32'h8C, 32'h44, 0, 1);
    stall = 1'b0;
    tick(32'h44, 32'h44, 0, 0);
    eret = 1'b0;
    tick(32'h80, 32'h48, 1, 1);
    go(32'h90);
    tick(32'h90, 32'h48, 0, 1);
    jump = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_epc", epc, 32'h0);
    chk("async_h", {31'b0, in_handler}, 32'h0);
    chk("async_valid", {31'b0, pc_valid}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
